// File: rtl/enc8_pkg.sv
// -----------------------------------------------------------------------------
// enc8_pkg
//   Shared types, widths and helpers for the serial one-hot encoder.
//   Code mapping mirrors the 3-to-8 one-hot decoder: vector bit 7 <-> code 000,
//   vector bit 0 <-> code 111 (code = 7 - index).
// -----------------------------------------------------------------------------
package enc8_pkg;

  localparam int CODE_W = 3;
  localparam int N_REQ  = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } enc_state_t;

  // Vector index to decoder-compatible code.
  function automatic logic [CODE_W-1:0] idx_to_code(input logic [CODE_W-1:0] idx);
    return 3'd7 - idx;
  endfunction

  // Number of set bits in a request vector (0..8).
  function automatic logic [CNT_W-1:0] popcount8(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] c;
    c = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/serial_onehot_encoder8_prio_pick8.sv
// -----------------------------------------------------------------------------
// prio_pick8
//   Combinational priority picker over the pending request vector.
//   Ports:
//     pending    in  8  bits still to be serviced
//     pick       out 3  index of the priority bit (highest if MSB_FIRST, else lowest)
//     clear_mask out 8  one-hot of the picked bit (all zero when nothing pending)
//     is_last    out 1  exactly one bit is pending
// -----------------------------------------------------------------------------
module prio_pick8
  import enc8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  pending,
  output logic [CODE_W-1:0] pick,
  output logic [N_REQ-1:0]  clear_mask,
  output logic              is_last
);

  logic any_s;

  // Priority scan: the last matching bit in scan order wins, so scanning
  // upward yields the highest set index and scanning downward the lowest.
  always_comb begin
    pick = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (MSB_FIRST) begin
        pick = pending[i] ? 3'(i) : pick;
      end else begin
        pick = pending[N_REQ-1-i] ? 3'(N_REQ-1-i) : pick;
      end
    end
  end

  // Mask and last-bit flag; v & (v-1) clears the lowest set bit, so a zero
  // result on a non-zero vector means a single bit is left.
  always_comb begin
    any_s      = (pending != 8'd0);
    clear_mask = any_s ? (8'd1 << pick) : 8'd0;
    is_last    = any_s && ((pending & (pending - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/serial_onehot_encoder8.sv
// -----------------------------------------------------------------------------
// serial_onehot_encoder8
//   Accepts an 8-bit request vector and emits the 3-bit code of every set bit,
//   one code per valid/ready handshake, in priority order.
//   Ports:
//     clk        in  1  rising-edge clock
//     rst_n      in  1  synchronous active-low reset
//     req_in     in  8  request vector, captured when a load is accepted
//     load       in  1  request vector valid
//     load_ready out 1  high only in IDLE
//     code       out 3  code of the serviced bit (7 - index), 000 when idle
//     out_valid  out 1  code valid (SERIAL state)
//     out_ready  in  1  consumer accepts code
//     out_last   out 1  current code is the final one of the vector
//     pend_cnt   out 4  set bits still pending including the current one
//     zero_err   out 1  one-cycle pulse after a load of an all-zero vector
// -----------------------------------------------------------------------------
module serial_onehot_encoder8
  import enc8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  input  logic              load,
  output logic              load_ready,
  output logic [CODE_W-1:0] code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              zero_err
);

  enc_state_t         state_r;
  enc_state_t         state_s;
  logic [N_REQ-1:0]   pending_r;
  logic [N_REQ-1:0]   pending_s;
  logic               zero_err_r;
  logic               zero_err_s;

  logic [CODE_W-1:0]  pick_s;
  logic [N_REQ-1:0]   clear_mask_s;
  logic               is_last_s;

  prio_pick8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_pick (
    .pending    (pending_r),
    .pick       (pick_s),
    .clear_mask (clear_mask_s),
    .is_last    (is_last_s)
  );

  // State, pending vector and zero-load flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pending_r  <= 8'd0;
      zero_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      pending_r  <= pending_s;
      zero_err_r <= zero_err_s;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_s    = state_r;
    pending_s  = pending_r;
    zero_err_s = 1'b0;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready = 1'b1;
        if (load) begin
          if (req_in != 8'd0) begin
            pending_s = req_in;
            state_s   = SERIAL;
          end else begin
            // Empty vector: nothing to serialise, just flag it.
            pending_s  = 8'd0;
            zero_err_s = 1'b1;
          end
        end else begin
          pending_s = 8'd0;
        end
      end
      SERIAL: begin
        // load is deliberately not looked at here.
        out_valid = 1'b1;
        if (out_ready) begin
          pending_s = pending_r & ~clear_mask_s;
          if (is_last_s) begin
            state_s = IDLE;
          end else begin
            state_s = SERIAL;
          end
        end else begin
          pending_s = pending_r;
        end
      end
      default: begin
        state_s   = IDLE;
        pending_s = 8'd0;
      end
    endcase
  end

  // Data outputs depend only on registered state, never on same-cycle inputs.
  // code is forced to 000 outside SERIAL so an empty picker does not show 111.
  always_comb begin
    if (state_r == SERIAL) begin
      code     = idx_to_code(pick_s);
      out_last = is_last_s;
    end else begin
      code     = 3'd0;
      out_last = 1'b0;
    end
    pend_cnt = popcount8(pending_r);
    zero_err = zero_err_r;
  end

endmodule

// File: tb/tb_serial_onehot_encoder8.sv
module tb_serial_onehot_encoder8;

  typedef struct {
    logic [2:0] code_m;
    logic [2:0] code_l;
    logic       last;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic       load;
  logic       out_ready;

  logic       lr_m, ov_m, ol_m, ze_m;
  logic [2:0] code_m;
  logic [3:0] pc_m;
  logic       lr_l, ov_l, ol_l, ze_l;
  logic [2:0] code_l;
  logic [3:0] pc_l;

  int n_cmp = 0;
  int n_err = 0;

  exp_t       q[$];
  logic [7:0] vec_q[$];
  logic [7:0] acc_m = 8'd0;
  logic [7:0] acc_l = 8'd0;

  always #5 clk = ~clk;

  serial_onehot_encoder8 #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .load(load), .load_ready(lr_m),
    .code(code_m), .out_valid(ov_m), .out_ready(out_ready), .out_last(ol_m),
    .pend_cnt(pc_m), .zero_err(ze_m)
  );

  serial_onehot_encoder8 #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .load(load), .load_ready(lr_l),
    .code(code_l), .out_valid(ov_l), .out_ready(out_ready), .out_last(ol_l),
    .pend_cnt(pc_l), .zero_err(ze_l)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 3-to-8 decoder model: code 000 -> bit 7 ... code 111 -> bit 0.
  function automatic logic [7:0] decode(input logic [2:0] c);
    logic [7:0] top;
    top = 8'h80;
    return top >> c;
  endfunction

  // Reference model: list of set bits, serviced descending (MSB_FIRST=1)
  // or ascending (MSB_FIRST=0); both instances see the same handshake count.
  task automatic push_expect(input logic [7:0] v);
    int   desc[$];
    int   p;
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) desc.push_back(i);
    end
    p = desc.size();
    for (int k = 0; k < p; k++) begin
      e.code_m = 3'(7 - desc[k]);
      e.code_l = 3'(7 - desc[p-1-k]);
      e.last   = (k == p - 1);
      e.cnt    = 4'(p - k);
      q.push_back(e);
    end
    vec_q.push_back(v);
  endtask

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] v;
    if (!rst_n) begin
      q.delete();
      vec_q.delete();
      acc_m = 8'd0;
      acc_l = 8'd0;
    end else if (ov_m || ov_l) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q[0];
        check("valid_m", int'(ov_m), 1);
        check("valid_l", int'(ov_l), 1);
        check("load_ready_busy", int'(lr_m | lr_l), 0);
        check("code_m", int'(code_m), int'(e.code_m));
        check("code_l", int'(code_l), int'(e.code_l));
        check("last_m", int'(ol_m), int'(e.last));
        check("last_l", int'(ol_l), int'(e.last));
        check("pend_cnt_m", int'(pc_m), int'(e.cnt));
        check("pend_cnt_l", int'(pc_l), int'(e.cnt));
        if (out_ready) begin
          void'(q.pop_front());
          acc_m = acc_m | decode(code_m);
          acc_l = acc_l | decode(code_l);
          if (e.last) begin
            v = (vec_q.size() != 0) ? vec_q.pop_front() : 8'd0;
            check("loopback_or_m", int'(acc_m), int'(v));
            check("loopback_or_l", int'(acc_l), int'(v));
            acc_m = 8'd0;
            acc_l = 8'd0;
          end
        end
      end
    end
  end

  // Called at #1 after an edge while both instances are IDLE.
  task automatic run_vec(input logic [7:0] v, input int mode, input bit noise);
    int cyc;
    bit done;
    push_expect(v);
    load      = 1'b1;
    req_in    = v;
    @(posedge clk); #1;
    load = 1'b0;
    done = 1'b0;
    for (cyc = 0; cyc < 60; cyc++) begin
      if (!ov_m) begin
        done = 1'b1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom % 2);
      endcase
      load   = noise ? 1'($urandom % 2) : 1'b0;
      req_in = 8'($urandom);
      @(posedge clk); #1;
    end
    load      = 1'b0;
    out_ready = 1'b0;
    if (!done) check("vector_timeout", 1, 0);
  endtask

  task automatic idle_checks();
    check("idle_load_ready_m", int'(lr_m), 1);
    check("idle_load_ready_l", int'(lr_l), 1);
    check("idle_valid_m", int'(ov_m), 0);
    check("idle_pend_cnt_m", int'(pc_m), 0);
    check("idle_code_m", int'(code_m), 0);
    check("idle_last_l", int'(ol_l), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    req_in    = 8'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_checks();
    check("reset_zero_err_m", int'(ze_m), 0);
    check("reset_pend_cnt_l", int'(pc_l), 0);

    run_vec(8'h80, 0, 1'b0);
    idle_checks();
    run_vec(8'hA5, 0, 1'b0);
    idle_checks();
    run_vec(8'hFF, 1, 1'b1);
    idle_checks();

    // All-zero load: one-cycle zero_err pulse, stays idle.
    load   = 1'b1;
    req_in = 8'h00;
    @(posedge clk); #1;
    load = 1'b0;
    check("zero_err_pulse_m", int'(ze_m), 1);
    check("zero_err_pulse_l", int'(ze_l), 1);
    check("zero_valid", int'(ov_m | ov_l), 0);
    check("zero_load_ready", int'(lr_m), 1);
    @(posedge clk); #1;
    check("zero_err_clear_m", int'(ze_m), 0);
    check("zero_err_clear_l", int'(ze_l), 0);

    run_vec(8'h3C, 2, 1'b1);
    idle_checks();

    // Reset mid-operation after the second code is presented.
    push_expect(8'h60);
    load      = 1'b1;
    req_in    = 8'h60;
    @(posedge clk); #1;
    load      = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_valid_m", int'(ov_m), 0);
    check("rst_mid_valid_l", int'(ov_l), 0);
    check("rst_mid_pend_cnt", int'(pc_m), 0);
    check("rst_mid_load_ready", int'(lr_l), 1);
    run_vec(8'h01, 0, 1'b0);
    idle_checks();

    for (int n = 0; n < 20; n++) begin
      run_vec(8'($urandom_range(1, 255)), $urandom_range(0, 2), 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);
    check("vectors_drained", vec_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
